// File: rtl/qsn_pipe_pkg.sv
// Shared helpers for the quasi-cyclic shift network: derived widths,
// element slicing and the (z, s) legality rule.
package qsn_pkg;

  function automatic int shift_w(input int max_z);
    return (max_z <= 2) ? 1 : $clog2(max_z);
  endfunction

  function automatic int z_w(input int max_z);
    return $clog2(max_z + 1);
  endfunction

  function automatic int latency(input int max_z);
    return shift_w(max_z) + 2;
  endfunction

  function automatic int elem_lo(input int i, input int dw);
    return i * dw;
  endfunction

  function automatic logic is_illegal(input int z, input int s, input int max_z);
    return (z < 1) || (z > max_z) || (s >= z);
  endfunction

endpackage

// File: rtl/qsn_pipe_if.sv
// Input and output stream bundle of the shift network.
interface qsn_pipe_if #(
  parameter int MAX_Z  = 8,
  parameter int DATA_W = 4,
  parameter int TAG_W  = 4
);
  localparam int SHIFT_W = qsn_pkg::shift_w(MAX_Z);
  localparam int Z_W     = qsn_pkg::z_w(MAX_Z);

  logic                      in_valid;
  logic                      in_ready;
  logic [MAX_Z*DATA_W-1:0]   in_data;
  logic [SHIFT_W-1:0]        in_shift;
  logic [Z_W-1:0]            in_z;
  logic                      in_dir;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [MAX_Z*DATA_W-1:0]   out_data;
  logic [TAG_W-1:0]          out_tag;
  logic                      out_err;

  modport master (
    output in_valid, in_data, in_shift, in_z, in_dir, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_z, in_dir, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/qsn_pipe_barrel_stage.sv
// One registered log-shifter step: moves the vector by 2**BIT elements when
// that bit of the carried amount is set, zero filling the vacated end.
module qsn_barrel_stage #(
  parameter int N   = 8,
  parameter int DW  = 4,
  parameter int AW  = 4,
  parameter int BIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            dir_up,
  input  logic            valid_in,
  input  logic [AW-1:0]   amount_in,
  input  logic [N*DW-1:0] data_in,
  output logic            valid_out,
  output logic [AW-1:0]   amount_out,
  output logic [N*DW-1:0] data_out
);
  localparam int STEP = (1 << BIT) * DW;

  logic [N*DW-1:0] shifted;

  always_comb begin
    shifted = data_in;
    if (amount_in[BIT]) shifted = dir_up ? (data_in << STEP) : (data_in >> STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      amount_out <= '0;
      data_out   <= '0;
    end else if (en) begin
      valid_out  <= valid_in;
      amount_out <= amount_in;
      data_out   <= shifted;
    end
  end
endmodule

// File: rtl/qsn_pipe.sv
// Pipelined quasi-cyclic rotate of the first z elements, built from two
// zero-filling barrel chains (A by e downwards, B by c = z - e upwards).
module qsn_pipe
  import qsn_pkg::*;
#(
  parameter int MAX_Z  = 8,
  parameter int DATA_W = 4,
  parameter int TAG_W  = 4
) (
  input logic       clk,
  input logic       rst,
  qsn_pipe_if.slave bus
);
  localparam int SHIFT_W = shift_w(MAX_Z);
  localparam int Z_W     = z_w(MAX_Z);
  localparam int VEC_W   = MAX_Z * DATA_W;

  logic             adv;
  logic [Z_W-1:0]   e_in, c_in;
  logic             v0;
  logic [VEC_W-1:0] d0;
  logic [Z_W-1:0]   e0, c0;

  logic             a_v [0:SHIFT_W];
  logic             b_v [0:SHIFT_W];
  logic [VEC_W-1:0] a_d [0:SHIFT_W];
  logic [VEC_W-1:0] b_d [0:SHIFT_W];
  logic [Z_W-1:0]   e_p [0:SHIFT_W];
  logic [Z_W-1:0]   c_p [0:SHIFT_W];
  logic [TAG_W-1:0] tag_p [0:SHIFT_W];
  logic             err_p [0:SHIFT_W];

  logic [VEC_W-1:0] merged;
  logic             out_valid_r, out_err_r;
  logic [VEC_W-1:0] out_data_r;
  logic [TAG_W-1:0] out_tag_r;

  assign adv          = !out_valid_r || bus.out_ready;
  assign bus.in_ready = adv;

  // an upward rotate by s is a downward rotate by z-s; s=0 must stay 0, not z
  always_comb begin
    e_in = Z_W'(bus.in_shift);
    if (bus.in_dir) e_in = (bus.in_shift == '0) ? '0 : bus.in_z - Z_W'(bus.in_shift);
    c_in = bus.in_z - e_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      d0 <= '0;
      e0 <= '0;
      c0 <= '0;
      for (int j = 0; j <= SHIFT_W; j++) begin
        tag_p[j] <= '0;
        err_p[j] <= 1'b0;
      end
    end else if (adv) begin
      v0       <= bus.in_valid;
      d0       <= bus.in_data;
      e0       <= e_in;
      c0       <= c_in;
      tag_p[0] <= bus.in_tag;
      err_p[0] <= is_illegal(int'(bus.in_z), int'(bus.in_shift), MAX_Z);
      for (int j = 1; j <= SHIFT_W; j++) begin
        tag_p[j] <= tag_p[j-1];
        err_p[j] <= err_p[j-1];
      end
    end
  end

  assign a_v[0] = v0;
  assign b_v[0] = v0;
  assign a_d[0] = d0;
  assign b_d[0] = d0;
  assign e_p[0] = e0;
  assign c_p[0] = c0;

  for (genvar j = 0; j < SHIFT_W; j++) begin : g_stage
    qsn_barrel_stage #(.N(MAX_Z), .DW(DATA_W), .AW(Z_W), .BIT(j)) u_a (
      .clk(clk), .rst(rst), .en(adv), .dir_up(1'b0),
      .valid_in(a_v[j]), .amount_in(e_p[j]), .data_in(a_d[j]),
      .valid_out(a_v[j+1]), .amount_out(e_p[j+1]), .data_out(a_d[j+1])
    );
    qsn_barrel_stage #(.N(MAX_Z), .DW(DATA_W), .AW(Z_W), .BIT(j)) u_b (
      .clk(clk), .rst(rst), .en(adv), .dir_up(1'b1),
      .valid_in(b_v[j]), .amount_in(c_p[j]), .data_in(b_d[j]),
      .valid_out(b_v[j+1]), .amount_out(c_p[j+1]), .data_out(b_d[j+1])
    );
  end

  // i+e<z is the same as i<c, and z itself is recovered as e+c
  always_comb begin
    merged = '0;
    for (int i = 0; i < MAX_Z; i++) begin
      if (i < int'(e_p[SHIFT_W]) + int'(c_p[SHIFT_W])) begin
        if (i < int'(c_p[SHIFT_W]))
          merged[elem_lo(i, DATA_W) +: DATA_W] = a_d[SHIFT_W][elem_lo(i, DATA_W) +: DATA_W];
        else
          merged[elem_lo(i, DATA_W) +: DATA_W] = b_d[SHIFT_W][elem_lo(i, DATA_W) +: DATA_W];
      end
    end
    if (err_p[SHIFT_W]) merged = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_tag_r   <= '0;
      out_err_r   <= 1'b0;
    end else if (adv) begin
      out_valid_r <= a_v[SHIFT_W] && b_v[SHIFT_W];
      out_data_r  <= merged;
      out_tag_r   <= tag_p[SHIFT_W];
      out_err_r   <= err_p[SHIFT_W];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_qsn_pipe.sv
// Scoreboard bench for qsn_pipe: expected vectors are queued at input
// transfer and popped by an independent output monitor.
module tb_qsn_pipe;
  localparam int MAX_Z  = 8;
  localparam int DATA_W = 4;
  localparam int TAG_W  = 4;
  localparam int LAT    = qsn_pkg::latency(MAX_Z);

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          push_cyc;
    bit          lc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  exp_t        sb[$];
  logic [31:0] cur_exp;
  logic        cur_err;
  bit          cur_lc;
  bit          hold_chk = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_tag;

  qsn_pipe_if #(.MAX_Z(MAX_Z), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  qsn_pipe #(.MAX_Z(MAX_Z), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // out[i] = in[(i+s) mod z] downwards, in[(i-s) mod z] upwards, zero above z
  function automatic logic [31:0] model(input logic [31:0] d, input int s, input int z, input bit dir);
    logic [31:0] r;
    int src;
    r = '0;
    if (z < 1 || z > MAX_Z || s >= z) return r;
    for (int i = 0; i < z; i++) begin
      src = dir ? (((i - s) % z) + z) % z : (i + s) % z;
      r[i*4 +: 4] = d[src*4 +: 4];
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input int s, input int z, input bit dir,
                      input logic [3:0] tag, input bit lc, input bit use_lit, input logic [31:0] lit);
    bit ok;
    int n;
    cur_exp = use_lit ? lit : model(d, s, z, dir);
    cur_err = (z < 1 || z > MAX_Z || s >= z);
    cur_lc  = lc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = 3'(s);
    bus.in_z     = 4'(z);
    bus.in_dir   = dir;
    bus.in_tag   = tag;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 32'(n), 32'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // input side: record what the bench expects for every accepted vector
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_t it;
      it.data = cur_exp;
      it.tag = bus.in_tag;
      it.err = cur_err;
      it.push_cyc = cyc;
      it.lc = cur_lc;
      sb.push_back(it);
    end
  end

  // output side
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", bus.out_data, held_data);
        chk("stall_tag", 32'(bus.out_tag), 32'(held_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_t it;
          it = sb.pop_front();
          chk("out_data", bus.out_data, it.data);
          chk("out_tag", 32'(bus.out_tag), 32'(it.tag));
          chk("out_err", 32'(bus.out_err), 32'(it.err));
          if (it.lc) chk("latency", 32'(cyc - it.push_cyc), 32'(LAT));
        end
      end
      hold_chk  = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_tag  = bus.out_tag;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int z, s, vcount;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shift = '0;
    bus.in_z     = '0;
    bus.in_dir   = 1'b0;
    bus.in_tag   = '0;
    cur_exp = '0;
    cur_err = 1'b0;
    cur_lc  = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'h76543210, 3, 8, 1'b0, 4'h1, 1'b1, 1'b1, 32'h21076543);
    send(32'h76543210, 2, 5, 1'b1, 4'h2, 1'b1, 1'b1, 32'h00021043);
    send(32'h76543210, 6, 6, 1'b0, 4'h3, 1'b1, 1'b1, 32'h0);
    send(32'h76543210, 0, 0, 1'b0, 4'h4, 1'b1, 1'b1, 32'h0);
    send(32'h76543210, 1, 8, 1'b1, 4'h5, 1'b1, 1'b1, 32'h65432107);
    send(32'hfedcba98, 0, 8, 1'b1, 4'h6, 1'b1, 1'b1, 32'hfedcba98);
    idle(8);

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        send($urandom, 0, $urandom_range(1, MAX_Z), 1'(k / 2), 4'(k), 1'b1, 1'b0, 32'h0);
      else
        send($urandom, 0, 1, 1'(k / 2), 4'(k), 1'b1, 1'b0, 32'h0);
      idle(k % 3);
    end
    drain();

    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      z = $urandom_range(1, MAX_Z);
      s = $urandom_range(0, z - 1);
      send($urandom, s, z, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 1'b0, 32'h0);
    end
    rand_ready = 1'b0;
    drain();

    for (int k = 0; k < 3; k++)
      send($urandom, 1, MAX_Z, 1'b0, 4'(k + 8), 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vcount = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("stale_after_rst", 32'(vcount), 32'd0);
    @(posedge clk);
    #1;
    send(32'h13579bdf, 2, 7, 1'b0, 4'hc, 1'b1, 1'b0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
